ad_ip_jesd204_tpl_dac_stream: RTL and testbench

//  Parametrised DMA-to-transport-layer sample streamer for the TPL DAC path. Buffers
//  DMA beats in a FWFT FIFO, gates start of transmission on fill level (and

---
 rtl/ad_ip_jesd204_tpl_dac_stream.sv | 169 ++++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_stream.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_stream.sv
// DMA-to-TPL DAC sample streamer: FWFT beat FIFO, fill-level start gating, link_ready
// backpressure, channel masking and underflow counting. Optional: AD_IP_JESD204_TPL_DAC_STREAM_EXT_TRIG_EN.
module ad_ip_jesd204_tpl_dac_stream #(
  parameter int NUM_CHANNELS    = 1,
  parameter int DATA_PATH_WIDTH = 4,
  parameter int BITS_PER_SAMPLE = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int START_THRESHOLD = 4,
  localparam int DATA_WIDTH     = NUM_CHANNELS * DATA_PATH_WIDTH * BITS_PER_SAMPLE,
  localparam int LEVEL_WIDTH    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    dma_valid,
  output logic                    dma_ready,
  input  logic [DATA_WIDTH-1:0]   dma_data,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic                    arm,
  input  logic                    stop,
  input  logic                    ext_trig,
  input  logic                    link_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [1:0]              state,
  output logic [LEVEL_WIDTH-1:0]  level,
  output logic [15:0]             underflow_cnt,
  input  logic                    underflow_clr
);

  localparam int CH_WIDTH = DATA_PATH_WIDTH * BITS_PER_SAMPLE;
  localparam int AW       = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILL      = 2'd1,
    ST_WAIT_TRIG = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                 state_r;
  logic [DATA_WIDTH-1:0]  mem_r [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [LEVEL_WIDTH-1:0] level_r;
  logic [15:0]            underflow_cnt_r;
  logic                   push_s;
  logic                   pop_s;
  logic                   empty_s;
  logic                   underflow_s;
  logic                   trig_s;

  function automatic logic [DATA_WIDTH-1:0] mask_channels(
    input logic [DATA_WIDTH-1:0]   data,
    input logic [NUM_CHANNELS-1:0] en
  );
    logic [DATA_WIDTH-1:0] res;
    res = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (en[i]) begin
        res[i*CH_WIDTH +: CH_WIDTH] = data[i*CH_WIDTH +: CH_WIDTH];
      end else begin
        res[i*CH_WIDTH +: CH_WIDTH] = {CH_WIDTH{1'b0}};
      end
    end
    return res;
  endfunction

`ifdef AD_IP_JESD204_TPL_DAC_STREAM_EXT_TRIG_EN
  logic trig_meta_r;
  logic trig_sync_r;
  logic trig_sync_d_r;

  // Two-flop synchroniser followed by a delay stage for rising-edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trig_meta_r   <= 1'b0;
      trig_sync_r   <= 1'b0;
      trig_sync_d_r <= 1'b0;
    end else begin
      trig_meta_r   <= ext_trig;
      trig_sync_r   <= trig_meta_r;
      trig_sync_d_r <= trig_sync_r;
    end
  end

  assign trig_s = trig_sync_r & ~trig_sync_d_r;
`else
  logic unused_ext_trig_s;
  assign unused_ext_trig_s = ext_trig;
  assign trig_s            = 1'b1;
`endif

  // A push is never allowed to rely on a same-cycle pop, so ready depends on level alone
  assign dma_ready   = (level_r != LEVEL_WIDTH'(FIFO_DEPTH));
  assign empty_s     = (level_r == {LEVEL_WIDTH{1'b0}});
  assign push_s      = dma_valid & dma_ready & (state_r != ST_IDLE) & ~stop;
  assign pop_s       = link_ready & (state_r == ST_RUN) & ~empty_s;
  assign underflow_s = link_ready & (state_r == ST_RUN) & empty_s;

  assign out_valid     = (state_r == ST_RUN);
  assign out_data      = ((state_r == ST_RUN) && !empty_s) ? mask_channels(mem_r[rd_ptr_r], enable)
                                                           : {DATA_WIDTH{1'b0}};
  assign state         = state_r;
  assign level         = level_r;
  assign underflow_cnt = underflow_cnt_r;

  // Streaming state machine; stop overrides every other transition
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else if (stop) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:      state_r <= arm ? ST_FILL : ST_IDLE;
        ST_FILL:      state_r <= (level_r >= LEVEL_WIDTH'(START_THRESHOLD)) ? ST_WAIT_TRIG : ST_FILL;
        ST_WAIT_TRIG: state_r <= trig_s ? ST_RUN : ST_WAIT_TRIG;
        ST_RUN:       state_r <= ST_RUN;
        default:      state_r <= ST_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; stop flushes the buffer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LEVEL_WIDTH{1'b0}};
    end else if (stop) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LEVEL_WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LEVEL_WIDTH'(1);
        2'b01:   level_r <= level_r - LEVEL_WIDTH'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Beat storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= dma_data;
    end
  end

  // Saturating underflow counter; clear wins over increment and stop leaves it alone
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      underflow_cnt_r <= 16'h0000;
    end else if (underflow_clr) begin
      underflow_cnt_r <= 16'h0000;
    end else if (underflow_s && (underflow_cnt_r != 16'hFFFF)) begin
      underflow_cnt_r <= underflow_cnt_r + 16'h0001;
    end else begin
      underflow_cnt_r <= underflow_cnt_r;
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_stream.sv
// Self-checking bench for ad_ip_jesd204_tpl_dac_stream (two channels), directed scenarios
// plus randomized traffic against a queue-based behavioural model.
module tb_ad_ip_jesd204_tpl_dac_stream;

  localparam int NCH   = 2;
  localparam int DEPTH = 8;
  localparam int THR   = 4;
  localparam int DW    = NCH * 4 * 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          dma_valid = 1'b0;
  logic [DW-1:0] dma_data = '0;
  logic [NCH-1:0] enable = 2'b11;
  logic          arm = 1'b0;
  logic          stop = 1'b0;
  logic          ext_trig = 1'b0;
  logic          link_ready = 1'b0;
  logic          underflow_clr = 1'b0;
  logic          dma_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    state;
  logic [LW-1:0] level;
  logic [15:0]   underflow_cnt;

  int checks = 0;
  int failures = 0;

  ad_ip_jesd204_tpl_dac_stream #(
    .NUM_CHANNELS(NCH), .DATA_PATH_WIDTH(4), .BITS_PER_SAMPLE(16),
    .FIFO_DEPTH(DEPTH), .START_THRESHOLD(THR)
  ) dut (
    .clk(clk), .resetn(resetn), .dma_valid(dma_valid), .dma_ready(dma_ready),
    .dma_data(dma_data), .enable(enable), .arm(arm), .stop(stop), .ext_trig(ext_trig),
    .link_ready(link_ready), .out_valid(out_valid), .out_data(out_data), .state(state),
    .level(level), .underflow_cnt(underflow_cnt), .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  // Behavioural model: beats held in a queue, state as a plain integer
  logic [DW-1:0] mq[$];
  int   m_state = 0;
  int   m_ucnt = 0;
  int   lvl_v = 0;
  int   nxt_v = 0;
  bit   rise_v = 1'b0;
  logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_state = 0; m_ucnt = 0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    end else begin
      lvl_v  = mq.size();
      // ext_trig reaches the edge detector two edges late; a rise is seen one edge after that
      rise_v = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = ext_trig;
`ifndef AD_IP_JESD204_TPL_DAC_STREAM_EXT_TRIG_EN
      rise_v = 1'b1;
`endif
      if (underflow_clr) m_ucnt = 0;
      else if (link_ready && m_state == 3 && lvl_v == 0 && m_ucnt < 65535) m_ucnt = m_ucnt + 1;
      if (stop) begin
        mq.delete();
        m_state = 0;
      end else begin
        if (link_ready && m_state == 3 && lvl_v > 0) void'(mq.pop_front());
        if (dma_valid && lvl_v < DEPTH && m_state != 0) mq.push_back(dma_data);
        nxt_v = m_state;
        if (m_state == 0 && arm) nxt_v = 1;
        if (m_state == 1 && lvl_v >= THR) nxt_v = 2;
        if (m_state == 2 && rise_v) nxt_v = 3;
        m_state = nxt_v;
      end
    end
  end

  function automatic logic [DW-1:0] exp_data();
    logic [DW-1:0] r;
    r = '0;
    if (m_state == 3 && mq.size() > 0)
      for (int c = 0; c < NCH; c++)
        if (enable[c]) r[c*64 +: 64] = mq[0][c*64 +: 64];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go_run(input int nbeats);
    stop = 1'b1; tick(); stop = 1'b0;
    link_ready = 1'b0; ext_trig = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      dma_valid = 1'b1; dma_data = rand_beat(); tick();
    end
    dma_valid = 1'b0;
`ifdef AD_IP_JESD204_TPL_DAC_STREAM_EXT_TRIG_EN
    repeat (3) tick();
    ext_trig = 1'b1;
`endif
    for (int i = 0; i < 20 && state !== 2'd3; i++) tick();
    checks++;
    if (state !== 2'd3) begin failures++; $display("FAIL go_run_timeout state=%0d required=3", state); end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) tick();
    checks += 6;
    if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    if (level !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    if (dma_ready !== 1'b1) begin failures++; $display("FAIL reset_dma_ready got=%b exp=1", dma_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    if (underflow_cnt !== 16'h0) begin failures++; $display("FAIL reset_ucnt got=%0d exp=0", underflow_cnt); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_start_gating();
    logic [15:0] p;
    enable = 2'b11; link_ready = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL gate_arm state=%0d exp=1", state); end
    for (int i = 0; i < 4; i++) begin
      p = 16'(16'h1111 * (i + 1));
      dma_valid = 1'b1; dma_data = {8{p}}; tick();
      checks += 2;
      if (state !== 2'd1) begin failures++; $display("FAIL gate_fill state=%0d exp=1", state); end
      if (level !== LW'(i + 1)) begin failures++; $display("FAIL gate_level got=%0d exp=%0d", level, i + 1); end
    end
    dma_valid = 1'b0;
`ifdef AD_IP_JESD204_TPL_DAC_STREAM_EXT_TRIG_EN
    ext_trig = 1'b1;
`endif
    tick();
    checks++;
    if (state !== 2'd2) begin failures++; $display("FAIL gate_wait state=%0d exp=2", state); end
    for (int i = 0; i < 4 && state !== 2'd3; i++) tick();
    ext_trig = 1'b0;
    checks += 3;
    if (state !== 2'd3) begin failures++; $display("FAIL gate_run state=%0d exp=3", state); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL gate_valid got=%b exp=1", out_valid); end
    if (out_data !== {8{16'h1111}}) begin failures++; $display("FAIL gate_first got=%h exp=%h", out_data, {8{16'h1111}}); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    link_ready = 1'b1; tick();
    checks += 2;
    if (out_data !== {8{16'h2222}}) begin failures++; $display("FAIL bp_pop1 got=%h exp=%h", out_data, {8{16'h2222}}); end
    if (level !== LW'(3)) begin failures++; $display("FAIL bp_level1 got=%0d exp=3", level); end
    held = {8{16'h2222}};
    link_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 2;
      if (out_data !== held) begin failures++; $display("FAIL bp_hold got=%h exp=%h", out_data, held); end
      if (level !== LW'(3)) begin failures++; $display("FAIL bp_hold_level got=%0d exp=3", level); end
    end
    link_ready = 1'b1; tick(); link_ready = 1'b0;
    checks += 3;
    if (out_data !== {8{16'h3333}}) begin failures++; $display("FAIL bp_pop2 got=%h exp=%h", out_data, {8{16'h3333}}); end
    if (level !== LW'(2)) begin failures++; $display("FAIL bp_level2 got=%0d exp=2", level); end
    if (underflow_cnt !== 16'h0) begin failures++; $display("FAIL bp_ucnt got=%0d exp=0", underflow_cnt); end
  endtask

  task automatic test_full_underflow();
    link_ready = 1'b0;
    for (int i = 0; i < 20 && mq.size() < DEPTH; i++) begin
      dma_valid = 1'b1; dma_data = rand_beat(); tick();
    end
    checks += 2;
    if (level !== LW'(DEPTH)) begin failures++; $display("FAIL full_level got=%0d exp=%0d", level, DEPTH); end
    if (dma_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", dma_ready); end
    dma_data = rand_beat(); tick();
    dma_valid = 1'b0;
    checks++;
    if (level !== LW'(DEPTH)) begin failures++; $display("FAIL full_overpush got=%0d exp=%0d", level, DEPTH); end
    link_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (out_data !== exp_data()) begin failures++; $display("FAIL drain_data got=%h exp=%h", out_data, exp_data()); end
      tick();
    end
    repeat (3) tick();
    checks += 4;
    if (level !== '0) begin failures++; $display("FAIL uf_level got=%0d exp=0", level); end
    if (out_data !== '0) begin failures++; $display("FAIL uf_data got=%h exp=0", out_data); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL uf_valid got=%b exp=1", out_valid); end
    if (underflow_cnt !== 16'd3) begin failures++; $display("FAIL uf_cnt got=%0d exp=3", underflow_cnt); end
    underflow_clr = 1'b1; tick(); underflow_clr = 1'b0; link_ready = 1'b0;
    checks++;
    if (underflow_cnt !== 16'd0) begin failures++; $display("FAIL uf_clr got=%0d exp=0", underflow_cnt); end
  endtask

  task automatic test_channel_mask();
    enable = 2'b01; link_ready = 1'b0;
    dma_valid = 1'b1; dma_data = {{4{16'hBBBB}}, {4{16'hAAAA}}}; tick();
    dma_valid = 1'b0;
    checks += 2;
    if (out_data !== {64'h0, 64'hAAAA_AAAA_AAAA_AAAA}) begin failures++; $display("FAIL mask_lo got=%h exp=%h", out_data, {64'h0, 64'hAAAA_AAAA_AAAA_AAAA}); end
    enable = 2'b10; #1;
    if (out_data !== {64'hBBBB_BBBB_BBBB_BBBB, 64'h0}) begin failures++; $display("FAIL mask_hi got=%h exp=%h", out_data, {64'hBBBB_BBBB_BBBB_BBBB, 64'h0}); end
    link_ready = 1'b1; tick(); link_ready = 1'b0; enable = 2'b11;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      checks += 6;
      if (state !== 2'(m_state)) begin failures++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", n, state, m_state); end
      if (level !== LW'(mq.size())) begin failures++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", n, level, mq.size()); end
      if (dma_ready !== (mq.size() != DEPTH)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b", n, dma_ready); end
      if (out_valid !== (m_state == 3)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b", n, out_valid); end
      if (out_data !== exp_data()) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", n, out_data, exp_data()); end
      if (underflow_cnt !== 16'(m_ucnt)) begin failures++; $display("FAIL rnd_ucnt cyc=%0d got=%0d exp=%0d", n, underflow_cnt, m_ucnt); end
      dma_valid     = ($urandom_range(0, 3) != 0);
      dma_data      = rand_beat();
      link_ready    = ($urandom_range(0, 2) != 0);
      enable        = NCH'($urandom_range(0, 3));
      underflow_clr = ($urandom_range(0, 15) == 0);
      stop          = ($urandom_range(0, 59) == 0);
      arm           = ($urandom_range(0, 7) == 0);
      ext_trig      = ($urandom_range(0, 5) == 0) ? ~ext_trig : ext_trig;
      tick();
    end
    dma_valid = 1'b0; link_ready = 1'b0; underflow_clr = 1'b0; stop = 1'b0; arm = 1'b0;
    ext_trig = 1'b0; enable = 2'b11;
  endtask

  task automatic test_stop_arm();
    go_run(5);
    stop = 1'b1; arm = 1'b1; dma_valid = 1'b1; dma_data = rand_beat(); tick();
    stop = 1'b0; arm = 1'b0; dma_valid = 1'b0;
    checks += 3;
    if (state !== 2'd0) begin failures++; $display("FAIL stoparm_state got=%0d exp=0", state); end
    if (level !== '0) begin failures++; $display("FAIL stoparm_level got=%0d exp=0", level); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL stoparm_valid got=%b exp=0", out_valid); end
    tick();
    checks++;
    if (state !== 2'd0) begin failures++; $display("FAIL stoparm_after got=%0d exp=0", state); end
  endtask

`ifdef AD_IP_JESD204_TPL_DAC_STREAM_EXT_TRIG_EN
  task automatic test_trigger();
    int cyc;
    stop = 1'b1; tick(); stop = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    ext_trig = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dma_valid = (i >= 2); dma_data = rand_beat(); tick();
    end
    dma_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (state !== 2'd2) begin failures++; $display("FAIL trig_fill_edge state=%0d exp=2", state); end
    ext_trig = 1'b0; repeat (3) tick();
    ext_trig = 1'b1;
    cyc = 0;
    for (int i = 0; i < 8 && state !== 2'd3; i++) begin tick(); cyc++; end
    checks++;
    if (cyc != 3) begin failures++; $display("FAIL trig_latency got=%0d exp=3", cyc); end
    ext_trig = 1'b0;
  endtask
`endif

  task automatic test_reset_midstream();
    go_run(5);
    checks++;
    if (level !== LW'(5)) begin failures++; $display("FAIL mid_pre_level got=%0d exp=5", level); end
    #2 resetn = 1'b0;
    #1;
    checks += 5;
    if (state !== 2'd0) begin failures++; $display("FAIL mid_state got=%0d exp=0", state); end
    if (level !== '0) begin failures++; $display("FAIL mid_level got=%0d exp=0", level); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    if (out_data !== '0) begin failures++; $display("FAIL mid_data got=%h exp=0", out_data); end
    if (dma_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", dma_ready); end
    ext_trig = 1'b0;
    @(negedge clk); resetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_start_gating();
    test_backpressure();
    test_full_underflow();
    test_channel_mask();
    test_random();
    test_stop_arm();
`ifdef AD_IP_JESD204_TPL_DAC_STREAM_EXT_TRIG_EN
    test_trigger();
`endif
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
